md4_round3_seq: RTL and testbench

Sequential MD4 round-3 engine that consumes the four 32-bit chaining words produced by the round-2 stage and the same 512-bit message block. It executes the 16 round-3 steps one per clock on a single shared datapath instead of 16 unrolled operators. Results go to the final chaining-value adder over a valid/ready handshake.

---
 rtl/md4_round3_seq.sv | 155 +++++++++++++++
 tb/tb_md4_round3_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/md4_round3_seq.sv
// MD4 round-3 engine: 16 steps executed one per clock on a single shared datapath,
// with valid/ready handshakes on both the input block and the output result.
module md4_round3_seq #(
  parameter logic [31:0] ROUND_K = 32'h6ED9EBA1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_a,
  input  logic [31:0]  in_b,
  input  logic [31:0]  in_c,
  input  logic [31:0]  in_d,
  input  logic [511:0] x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_a,
  output logic [31:0]  out_b,
  output logic [31:0]  out_c,
  output logic [31:0]  out_d,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic           load_s;
  logic           step_en_s;
  logic [3:0]     step_r;
  logic [31:0]    a_r, b_r, c_r, d_r;
  logic [511:0]   x_r;
  logic [31:0]    out_a_r, out_b_r, out_c_r, out_d_r;
  logic [3:0]     k_s;
  logic [31:0]    xk_s;
  logic [31:0]    sum_s;
  logic [31:0]    new_s;

  // Next-state decode and load/step strobes.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_en_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          load_s      = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        step_en_s = 1'b1;
        if (step_r == 4'd15) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_ready && in_valid) begin
          load_s      = 1'b1;
          state_nxt_s = RUN;
        end else if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Message word index is the bit-reversed step number.
  assign k_s   = {step_r[0], step_r[1], step_r[2], step_r[3]};
  assign xk_s  = x_r[{k_s, 5'd0} +: 32];
  assign sum_s = a_r + (b_r ^ c_r ^ d_r) + xk_s + ROUND_K;

  // Constant-select rotator; shift amount depends only on step[1:0].
  always_comb begin
    new_s = sum_s;
    case (step_r[1:0])
      2'd0:    new_s = {sum_s[28:0], sum_s[31:29]};
      2'd1:    new_s = {sum_s[22:0], sum_s[31:23]};
      2'd2:    new_s = {sum_s[20:0], sum_s[31:21]};
      2'd3:    new_s = {sum_s[16:0], sum_s[31:17]};
      default: new_s = sum_s;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Working registers, captured message and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= 32'd0;
      b_r    <= 32'd0;
      c_r    <= 32'd0;
      d_r    <= 32'd0;
      x_r    <= 512'd0;
      step_r <= 4'd0;
    end else if (load_s) begin
      a_r    <= in_a;
      b_r    <= in_b;
      c_r    <= in_c;
      d_r    <= in_d;
      x_r    <= x;
      step_r <= 4'd0;
    end else if (step_en_s) begin
      a_r    <= d_r;
      b_r    <= new_s;
      c_r    <= b_r;
      d_r    <= c_r;
      step_r <= step_r + 4'd1;
    end
  end

  // Result registers update only as the last step retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a_r <= 32'd0;
      out_b_r <= 32'd0;
      out_c_r <= 32'd0;
      out_d_r <= 32'd0;
    end else if (step_en_s && (step_r == 4'd15)) begin
      out_a_r <= d_r;
      out_b_r <= new_s;
      out_c_r <= b_r;
      out_d_r <= c_r;
    end
  end

  assign out_a     = out_a_r;
  assign out_b     = out_b_r;
  assign out_c     = out_c_r;
  assign out_d     = out_d_r;
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r == RUN);
  assign in_ready  = (state_r == IDLE) | ((state_r == DONE) & out_ready);

endmodule

// File: tb/tb_md4_round3_seq.sv
// Directed bench for md4_round3_seq with a textbook MD4 round-3 reference and scoreboard.
module tb_md4_round3_seq;

  localparam logic [31:0] K = 32'h6ED9EBA1;
  localparam int KS [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  localparam int SS [4]  = '{3, 9, 11, 15};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [31:0]  in_a = 32'd0, in_b = 32'd0, in_c = 32'd0, in_d = 32'd0;
  logic [511:0] x = 512'd0;
  logic         in_ready, out_valid, busy;
  logic [31:0]  out_a, out_b, out_c, out_d;

  int n_pass = 0;
  int n_chk = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int prev_acc_cyc = 0;
  int n_acc = 0;
  logic [127:0] sb [$];

  md4_round3_seq #(.ROUND_K(K)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .x(x),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [31:0] md4_step(input logic [31:0] a, b, c, d, xk, input int s);
    return rotl(a + (b ^ c ^ d) + xk + K, s);
  endfunction

  // Textbook form: A,D,C,B updated in turn in place, no register shuffling.
  function automatic logic [127:0] md4_r3(input logic [31:0] a, b, c, d, input logic [511:0] m);
    logic [31:0] v [4];
    int t;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 16; i++) begin
      t = (4 - (i % 4)) % 4;
      v[t] = md4_step(v[t], v[(t + 1) % 4], v[(t + 2) % 4], v[(t + 3) % 4],
                      m[32 * KS[i] +: 32], SS[i % 4]);
    end
    return {v[0], v[1], v[2], v[3]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Accept monitor: model result for each handshaken block goes to the scoreboard.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && in_valid && in_ready) begin
      sb.push_back(md4_r3(in_a, in_b, in_c, in_d, x));
      prev_acc_cyc = acc_cyc;
      acc_cyc = cyc;
      n_acc++;
    end
  end

  // Compare process: every cycle a result is presented it must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 128'd1, 128'd0);
      end else begin
        chk("result", {out_a, out_b, out_c, out_d}, sb[0]);
        if (out_ready) sb.delete(0);
      end
    end
  end

  task automatic send(input logic [31:0] a, b, c, d, input logic [511:0] m);
    in_valid = 1'b1;
    in_a = a; in_b = b; in_c = c; in_d = d; x = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("timeout_out_valid", 128'd0, 128'd1);
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int n_ov;
    int base;
    logic [127:0] held;
    logic [511:0] m;

    // Model pins against hand-worked values.
    chk("pin_rotl3", rotl(32'h6ED9EBA1, 3), 32'h76CF5D0B);
    chk("pin_rotl9", rotl(32'h80000001, 9), 32'h00000300);
    chk("pin_step_zero", md4_step(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3), 32'h76CF5D0B);
    chk("pin_step_a1", md4_step(32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 3), 32'h76CF5D13);

    // Power-on reset, checked before any clock edge.
    #2;
    chk("rst_outs", {out_a, out_b, out_c, out_d}, 128'd0);
    chk("rst_flags", {in_ready, out_valid, busy}, {1'b1, 1'b0, 1'b0});
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // All-zero block: step-0 word, latency and busy length.
    out_ready = 1'b1;
    send(32'd0, 32'd0, 32'd0, 32'd0, 512'd0);
    busy_cnt = int'(busy);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) chk("step0_b", dut.b_r, 32'h76CF5D0B);
      if (lat == 5) chk("run_in_ready", in_ready, 1'b0);
      if (busy) busy_cnt++;
    end
    chk("latency", lat, 16);
    chk("busy_len", busy_cnt, 16);
    @(posedge clk); #1;

    // Round-2 output vector with a padded one-word message.
    m = 512'd0;
    m[31:0] = 32'h50535554;
    m[63:32] = 32'h00000080;
    m[479:448] = 32'h00000020;
    send(32'h9cf79903, 32'h6472bcbb, 32'h073a3859, 32'h17ea3e30, m);
    wait_out(lat);
    @(posedge clk); #1;

    // Backpressure: result held, no new accept, then retire.
    out_ready = 1'b0;
    send(32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210, {16{32'hdeadbeef}});
    wait_out(lat);
    held = {out_a, out_b, out_c, out_d};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_valid", out_valid, 1'b1);
    end
    chk("bp_in_ready_release", in_ready, 1'b0);
    out_ready = 1'b1;
    #0 chk("ready_follows_out_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    chk("bp_valid_fall", out_valid, 1'b0);
    @(posedge clk); #1;
    chk("idle_hold", {out_a, out_b, out_c, out_d}, held);

    // Mid-cycle asynchronous reset clears outputs immediately.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {out_a, out_b, out_c, out_d}, 128'd0);
    chk("async_rst_flags", {in_ready, out_valid, busy}, {1'b1, 1'b0, 1'b0});
    sb.delete();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset during step 7 aborts the block.
    send(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, {16{32'h5a5a5a5a}});
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    sb.delete();
    #2 rst_n = 1'b1;
    n_ov = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) n_ov++;
    end
    chk("abort_no_valid", n_ov, 0);

    // Back-to-back: second block taken the cycle the first retires.
    base = n_acc;
    in_valid = 1'b1;
    in_a = 32'hcafef00d; in_b = 32'h0badc0de; in_c = 32'h13579bdf; in_d = 32'h2468ace0;
    x = {16{32'h0f1e2d3c}};
    @(posedge clk); #1;
    in_a = 32'ha5a5a5a5; in_b = 32'h3c3c3c3c; in_c = 32'hffffffff; in_d = 32'h00000001;
    m = 512'd0;
    for (int i = 0; i < 16; i++) m[32 * i +: 32] = 32'h01010101 * (i + 1);
    x = m;
    lat = 0;
    while (n_acc < base + 2 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("b2b_accepts", n_acc - base, 2);
    chk("b2b_interval", acc_cyc - prev_acc_cyc, 17);
    wait_out(lat);
    @(posedge clk); #1;

    // Input isolation: upstream churns x and in_a during RUN.
    send(32'h76543210, 32'hfedcba98, 32'h89abcdef, 32'h01234567, {16{32'h600dcafe}});
    for (int i = 0; i < 16; i++) begin
      x = {16{$urandom}};
      in_a = $urandom;
      @(posedge clk); #1;
    end
    wait_out(lat);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
